// File: rtl/arp_pkg.sv
// Shared ARP transmit constants, frame record and state encoding.
// Frame length follows ARP_PAD_EN: 60 bytes when defined, 42 bytes otherwise.
package arp_pkg;

    localparam logic [15:0] ETH_TYPE_ARP  = 16'h0806;
    localparam logic [15:0] HTYPE_ETH     = 16'h0001;
    localparam logic [15:0] PTYPE_IPV4    = 16'h0800;
    localparam logic [7:0]  HLEN          = 8'd6;
    localparam logic [7:0]  PLEN          = 8'd4;
    localparam logic [15:0] OP_REQUEST    = 16'h0001;
    localparam logic [15:0] OP_REPLY      = 16'h0002;
    localparam int          ARP_FRAME_LEN = 42;
    localparam int          ETH_MIN_LEN   = 60;

`ifdef ARP_PAD_EN
    localparam int FRAME_LEN = ETH_MIN_LEN;
`else
    localparam int FRAME_LEN = ARP_FRAME_LEN;
`endif

    localparam logic [5:0] LAST_IDX = 6'(FRAME_LEN - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_SEND = 2'd2,
        ST_GAP  = 2'd3
    } arp_state_e;

    typedef struct packed {
        logic [47:0] dst_mac;
        logic [47:0] src_mac;
        logic [31:0] src_ip;
        logic [15:0] opcode;
        logic [47:0] tgt_mac;
        logic [31:0] tgt_ip;
    } arp_frame_t;

    // Ethernet header plus ARP payload, byte 0 in the top bits.
    function automatic logic [335:0] arp_header(input arp_frame_t f);
        return {f.dst_mac, f.src_mac, ETH_TYPE_ARP, HTYPE_ETH, PTYPE_IPV4,
                HLEN, PLEN, f.opcode, f.src_mac, f.src_ip, f.tgt_mac, f.tgt_ip};
    endfunction

endpackage

// File: rtl/arp_frame_mux.sv
// Combinational byte selector: returns frame byte idx, or PAD_BYTE past the ARP payload.
module arp_frame_mux
    import arp_pkg::*;
#(
    parameter logic [7:0] PAD_BYTE = 8'h00
) (
    input  arp_frame_t  frame,
    input  logic [5:0]  idx,
    output logic [7:0]  byte_out
);

    logic [335:0] hdr_s;
    logic [8:0]   bit_off_s;

    // Pick the addressed byte from the packed header image.
    always_comb begin
        hdr_s     = arp_header(frame);
        bit_off_s = {6'd41 - idx, 3'b000};
        if (idx > 6'd41) begin
            byte_out = PAD_BYTE;
        end else begin
            byte_out = hdr_s[bit_off_s +: 8];
        end
    end

endmodule

// File: rtl/arp_tx.sv
// ARP request/reply frame transmitter streaming Ethernet II frames bytewise.
// Optional ARP_PAD_EN pads frames to 60 bytes with PAD_BYTE.
module arp_tx
    import arp_pkg::*;
#(
    parameter int unsigned GAP_CYCLES = 12,
    parameter logic [7:0]  PAD_BYTE   = 8'h00
) (
    input  logic        tx_clk,
    input  logic        reset,
    input  logic [47:0] local_mac,
    input  logic [31:0] local_ip,
    input  logic        request_send_en,
    input  logic [31:0] request_ip_addr,
    input  logic        reply_send_en,
    input  logic [47:0] reply_mac_addr,
    input  logic [31:0] reply_ip_addr,
    output logic [7:0]  arp_tx_data,
    output logic        arp_tx_valid,
    output logic        arp_tx_last,
    input  logic        arp_tx_ready,
    output logic        busy
);

    localparam logic [7:0] GAP_LAST = 8'(GAP_CYCLES - 1);

    arp_state_e  state_q, state_d;
    logic        req_pend_q, req_pend_d;
    logic        rep_pend_q, rep_pend_d;
    logic [31:0] req_ip_q, req_ip_d;
    logic [47:0] rep_mac_q, rep_mac_d;
    logic [31:0] rep_ip_q, rep_ip_d;
    arp_frame_t  frame_q, frame_d;
    logic [5:0]  cnt_q, cnt_d;
    logic [7:0]  gap_q, gap_d;
    logic [7:0]  data_q, data_d;
    logic        valid_q, valid_d;
    logic        last_q, last_d;
    logic        busy_q, busy_d;

    logic        consume_rep_s;
    logic        consume_req_s;
    logic        load_byte_s;
    logic        clear_byte_s;
    logic [7:0]  byte_s;

    arp_frame_mux #(.PAD_BYTE(PAD_BYTE)) u_mux (
        .frame    (frame_d),
        .idx      (cnt_d),
        .byte_out (byte_s)
    );

    // Pending latches, FSM next state, counters and frame snapshot.
    always_comb begin
        state_d      = state_q;
        req_pend_d   = req_pend_q;
        rep_pend_d   = rep_pend_q;
        req_ip_d     = req_ip_q;
        rep_mac_d    = rep_mac_q;
        rep_ip_d     = rep_ip_q;
        frame_d      = frame_q;
        cnt_d        = cnt_q;
        gap_d        = gap_q;
        valid_d      = valid_q;
        last_d       = last_q;
        load_byte_s  = 1'b0;
        clear_byte_s = 1'b0;

        consume_rep_s = (state_q == ST_LOAD) && rep_pend_q;
        consume_req_s = (state_q == ST_LOAD) && !rep_pend_q && req_pend_q;

        // A fresh pulse outranks the clear from a concurrent LOAD.
        if (request_send_en) begin
            req_pend_d = 1'b1;
            req_ip_d   = request_ip_addr;
        end else if (consume_req_s) begin
            req_pend_d = 1'b0;
        end else begin
            req_pend_d = req_pend_q;
        end

        if (reply_send_en) begin
            rep_pend_d = 1'b1;
            rep_mac_d  = reply_mac_addr;
            rep_ip_d   = reply_ip_addr;
        end else if (consume_rep_s) begin
            rep_pend_d = 1'b0;
        end else begin
            rep_pend_d = rep_pend_q;
        end

        case (state_q)
            ST_IDLE: begin
                if (rep_pend_q || req_pend_q || request_send_en || reply_send_en) begin
                    state_d = ST_LOAD;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_LOAD: begin
                frame_d.src_mac = local_mac;
                frame_d.src_ip  = local_ip;
                if (consume_rep_s) begin
                    frame_d.dst_mac = rep_mac_q;
                    frame_d.opcode  = OP_REPLY;
                    frame_d.tgt_mac = rep_mac_q;
                    frame_d.tgt_ip  = rep_ip_q;
                end else begin
                    frame_d.dst_mac = 48'hFFFF_FFFF_FFFF;
                    frame_d.opcode  = OP_REQUEST;
                    frame_d.tgt_mac = 48'h0000_0000_0000;
                    frame_d.tgt_ip  = req_ip_q;
                end
                if (consume_rep_s || consume_req_s) begin
                    state_d     = ST_SEND;
                    cnt_d       = 6'd0;
                    valid_d     = 1'b1;
                    last_d      = 1'b0;
                    load_byte_s = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SEND: begin
                if (arp_tx_ready) begin
                    if (cnt_q == LAST_IDX) begin
                        state_d      = ST_GAP;
                        gap_d        = 8'd0;
                        valid_d      = 1'b0;
                        last_d       = 1'b0;
                        clear_byte_s = 1'b1;
                    end else begin
                        cnt_d       = cnt_q + 6'd1;
                        last_d      = (cnt_d == LAST_IDX);
                        load_byte_s = 1'b1;
                    end
                end else begin
                    state_d = ST_SEND;
                end
            end
            ST_GAP: begin
                if (gap_q == GAP_LAST) begin
                    state_d = ST_IDLE;
                    gap_d   = 8'd0;
                end else begin
                    gap_d = gap_q + 8'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = req_pend_d | rep_pend_d | (state_d != ST_IDLE);
    end

    // Output byte register fed from the mux at the next index.
    always_comb begin
        if (load_byte_s) begin
            data_d = byte_s;
        end else if (clear_byte_s) begin
            data_d = 8'h00;
        end else begin
            data_d = data_q;
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge tx_clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            req_pend_q <= 1'b0;
            rep_pend_q <= 1'b0;
            req_ip_q   <= 32'd0;
            rep_mac_q  <= 48'd0;
            rep_ip_q   <= 32'd0;
            frame_q    <= '0;
            cnt_q      <= 6'd0;
            gap_q      <= 8'd0;
            data_q     <= 8'h00;
            valid_q    <= 1'b0;
            last_q     <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            req_pend_q <= req_pend_d;
            rep_pend_q <= rep_pend_d;
            req_ip_q   <= req_ip_d;
            rep_mac_q  <= rep_mac_d;
            rep_ip_q   <= rep_ip_d;
            frame_q    <= frame_d;
            cnt_q      <= cnt_d;
            gap_q      <= gap_d;
            data_q     <= data_d;
            valid_q    <= valid_d;
            last_q     <= last_d;
            busy_q     <= busy_d;
        end
    end

    assign arp_tx_data  = data_q;
    assign arp_tx_valid = valid_q;
    assign arp_tx_last  = last_q;
    assign busy         = busy_q;

endmodule

// File: tb/tb_arp_tx.sv
// Self-checking bench for arp_tx: table of frame vectors plus hand-written corner sequences,
// with a byte scoreboard fed by a bench-side frame model.
module tb_arp_tx;

`ifdef ARP_PAD_EN
    localparam int N = 60;
`else
    localparam int N = 42;
`endif
    localparam logic [47:0] LMAC = 48'h000A_3501_0203;
    localparam logic [31:0] LIP  = 32'hC0A8_010A;

    logic        tx_clk = 1'b0;
    logic        reset;
    logic [47:0] local_mac;
    logic [31:0] local_ip;
    logic        request_send_en;
    logic [31:0] request_ip_addr;
    logic        reply_send_en;
    logic [47:0] reply_mac_addr;
    logic [31:0] reply_ip_addr;
    logic [7:0]  arp_tx_data;
    logic        arp_tx_valid;
    logic        arp_tx_last;
    logic        arp_tx_ready;
    logic        busy;

    arp_tx dut (
        .tx_clk          (tx_clk),
        .reset           (reset),
        .local_mac       (local_mac),
        .local_ip        (local_ip),
        .request_send_en (request_send_en),
        .request_ip_addr (request_ip_addr),
        .reply_send_en   (reply_send_en),
        .reply_mac_addr  (reply_mac_addr),
        .reply_ip_addr   (reply_ip_addr),
        .arp_tx_data     (arp_tx_data),
        .arp_tx_valid    (arp_tx_valid),
        .arp_tx_last     (arp_tx_last),
        .arp_tx_ready    (arp_tx_ready),
        .busy            (busy)
    );

    always #5 tx_clk = ~tx_clk;

    typedef struct {
        logic [7:0] data;
        logic       last;
    } exp_t;

    typedef struct {
        bit          is_rep;
        logic [47:0] mac;
        logic [31:0] ip;
        bit          bp;
        logic [7:0]  e_b0;
        logic [7:0]  e_b21;
        logic [7:0]  e_b32;
        logic [7:0]  e_b41;
    } vec_t;

    exp_t       sbq[$];
    vec_t       vecs[4];
    int         tests = 0;
    int         fails = 0;
    logic [7:0] cap[0:127];
    int         cap_n = 0;
    bit         bp_mode = 1'b0;
    bit         prev_stall = 1'b0;
    logic [7:0] prev_data;
    logic       prev_last;
    int         idle_run = 0;
    int         last_gap = -1;
    bit         after_last = 1'b0;
    int         valid_seen = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic void push_frame(input bit is_rep, input logic [47:0] lmac,
                                       input logic [31:0] lip, input logic [47:0] tmac,
                                       input logic [31:0] tip);
        logic [7:0] b[0:59];
        exp_t       e;
        for (int i = 0; i < 6; i++) begin
            b[i]      = is_rep ? tmac[47-8*i -: 8] : 8'hFF;
            b[6+i]    = lmac[47-8*i -: 8];
            b[22+i]   = lmac[47-8*i -: 8];
            b[32+i]   = is_rep ? tmac[47-8*i -: 8] : 8'h00;
        end
        b[12] = 8'h08; b[13] = 8'h06; b[14] = 8'h00; b[15] = 8'h01;
        b[16] = 8'h08; b[17] = 8'h00; b[18] = 8'h06; b[19] = 8'h04;
        b[20] = 8'h00; b[21] = is_rep ? 8'h02 : 8'h01;
        for (int i = 0; i < 4; i++) begin
            b[28+i] = lip[31-8*i -: 8];
            b[38+i] = tip[31-8*i -: 8];
        end
        for (int i = 42; i < 60; i++) b[i] = 8'h00;
        for (int i = 0; i < N; i++) begin
            e.data = b[i];
            e.last = (i == N - 1);
            sbq.push_back(e);
        end
    endfunction

    // One clock: monitor at the falling edge, then return just after the rising edge.
    task automatic step();
        exp_t e;
        @(negedge tx_clk);
        if (prev_stall) begin
            check("hold_valid", {63'd0, arp_tx_valid}, 64'd1);
            check("hold_data", {56'd0, arp_tx_data}, {56'd0, prev_data});
            check("hold_last", {63'd0, arp_tx_last}, {63'd0, prev_last});
        end
        if (arp_tx_valid) begin
            valid_seen++;
            if (after_last) begin
                last_gap   = idle_run;
                after_last = 1'b0;
            end
        end else begin
            idle_run++;
        end
        if (arp_tx_valid && arp_tx_ready) begin
            if (sbq.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL extra_byte: got %0h expected none", arp_tx_data);
            end else begin
                e = sbq.pop_front();
                check($sformatf("byte%0d", cap_n), {56'd0, arp_tx_data}, {56'd0, e.data});
                check($sformatf("last%0d", cap_n), {63'd0, arp_tx_last}, {63'd0, e.last});
            end
            if (cap_n < 128) cap[cap_n] = arp_tx_data;
            cap_n++;
            if (arp_tx_last) begin
                after_last = 1'b1;
                idle_run   = 0;
            end
        end
        prev_stall = arp_tx_valid && !arp_tx_ready && !reset;
        prev_data  = arp_tx_data;
        prev_last  = arp_tx_last;
        @(posedge tx_clk);
        #1;
        arp_tx_ready = bp_mode ? 1'($urandom_range(0, 1)) : 1'b1;
    endtask

    task automatic run_idle(input int max);
        int k = 0;
        while ((busy || sbq.size() != 0) && k < max) begin
            step();
            k++;
        end
        tests++;
        if (k >= max) begin
            fails++;
            $display("FAIL idle_timeout: got busy=%0d queued=%0d expected idle", busy, sbq.size());
        end
    endtask

    task automatic wait_cap(input int n, input int max);
        int k = 0;
        while (cap_n < n && k < max) begin
            step();
            k++;
        end
        tests++;
        if (cap_n < n) begin
            fails++;
            $display("FAIL wait_cap: got %0d bytes expected %0d", cap_n, n);
        end
    endtask

    initial begin
        vecs[0] = '{1'b0, 48'h0, 32'hC0A8_0114, 1'b0, 8'hFF, 8'h01, 8'h00, 8'h14};
        vecs[1] = '{1'b1, 48'h1122_3344_5566, 32'hC0A8_011E, 1'b0, 8'h11, 8'h02, 8'h11, 8'h1E};
        vecs[2] = '{1'b0, 48'h0, 32'hC0A8_0115, 1'b1, 8'hFF, 8'h01, 8'h00, 8'h15};
        vecs[3] = '{1'b1, 48'h0A0B_0C0D_0E0F, 32'h0A00_0001, 1'b1, 8'h0A, 8'h02, 8'h0A, 8'h01};

        reset = 1'b1;
        local_mac = LMAC;
        local_ip = LIP;
        request_send_en = 1'b0;
        request_ip_addr = 32'd0;
        reply_send_en = 1'b0;
        reply_mac_addr = 48'd0;
        reply_ip_addr = 32'd0;
        arp_tx_ready = 1'b1;
        repeat (3) step();
        check("rst_valid", {63'd0, arp_tx_valid}, 64'd0);
        check("rst_last", {63'd0, arp_tx_last}, 64'd0);
        check("rst_data", {56'd0, arp_tx_data}, 64'd0);
        check("rst_busy", {63'd0, busy}, 64'd0);
        reset = 1'b0;
        step();

        for (int v = 0; v < 4; v++) begin
            cap_n   = 0;
            bp_mode = vecs[v].bp;
            if (vecs[v].is_rep) begin
                reply_send_en  = 1'b1;
                reply_mac_addr = vecs[v].mac;
                reply_ip_addr  = vecs[v].ip;
            end else begin
                request_send_en = 1'b1;
                request_ip_addr = vecs[v].ip;
            end
            push_frame(vecs[v].is_rep, LMAC, LIP, vecs[v].mac, vecs[v].ip);
            step();
            request_send_en = 1'b0;
            reply_send_en   = 1'b0;
            check($sformatf("v%0d_lat_c1", v), {63'd0, arp_tx_valid}, 64'd0);
            step();
            check($sformatf("v%0d_lat_c2", v), {63'd0, arp_tx_valid}, 64'd1);
            run_idle(600);
            check($sformatf("v%0d_count", v), 64'(cap_n), 64'(N));
            check($sformatf("v%0d_b0", v), {56'd0, cap[0]}, {56'd0, vecs[v].e_b0});
            check($sformatf("v%0d_b21", v), {56'd0, cap[21]}, {56'd0, vecs[v].e_b21});
            check($sformatf("v%0d_b32", v), {56'd0, cap[32]}, {56'd0, vecs[v].e_b32});
            check($sformatf("v%0d_b41", v), {56'd0, cap[41]}, {56'd0, vecs[v].e_b41});
            check($sformatf("v%0d_busy_end", v), {63'd0, busy}, 64'd0);
        end
        bp_mode = 1'b0;
        step();

        // Simultaneous pulses: reply first, then request after the gap.
        begin
            bit busy_dropped = 1'b0;
            int k = 0;
            cap_n = 0;
            last_gap = -1;
            request_send_en = 1'b1;
            request_ip_addr = 32'hC0A8_0114;
            reply_send_en   = 1'b1;
            reply_mac_addr  = 48'h1122_3344_5566;
            reply_ip_addr   = 32'hC0A8_011E;
            push_frame(1'b1, LMAC, LIP, 48'h1122_3344_5566, 32'hC0A8_011E);
            push_frame(1'b0, LMAC, LIP, 48'h0, 32'hC0A8_0114);
            step();
            request_send_en = 1'b0;
            reply_send_en   = 1'b0;
            while (sbq.size() != 0 && k < 600) begin
                step();
                if (!busy) busy_dropped = 1'b1;
                k++;
            end
            check("sim_busy_held", {63'd0, busy_dropped}, 64'd0);
            run_idle(100);
            check("sim_count", 64'(cap_n), 64'(2 * N));
            check("sim_gap_ge_12", {63'd0, last_gap >= 12}, 64'd1);
            check("sim_busy_end", {63'd0, busy}, 64'd0);
        end

        // Second request pulsed mid-frame is sent after the first frame.
        cap_n = 0;
        request_send_en = 1'b1;
        request_ip_addr = 32'hC0A8_0114;
        push_frame(1'b0, LMAC, LIP, 48'h0, 32'hC0A8_0114);
        step();
        request_send_en = 1'b0;
        wait_cap(30, 200);
        request_send_en = 1'b1;
        request_ip_addr = 32'hC0A8_0115;
        push_frame(1'b0, LMAC, LIP, 48'h0, 32'hC0A8_0115);
        step();
        request_send_en = 1'b0;
        run_idle(600);
        check("mid_count", 64'(cap_n), 64'(2 * N));
        check("mid_ip_lo", {56'd0, cap[N + 41]}, 64'h15);

        // Reset mid-frame discards the frame and any pending work.
        cap_n = 0;
        request_send_en = 1'b1;
        request_ip_addr = 32'hC0A8_0114;
        push_frame(1'b0, LMAC, LIP, 48'h0, 32'hC0A8_0114);
        step();
        request_send_en = 1'b0;
        wait_cap(10, 200);
        reply_send_en  = 1'b1;
        reply_mac_addr = 48'h1122_3344_5566;
        reply_ip_addr  = 32'hC0A8_011E;
        step();
        reply_send_en = 1'b0;
        wait_cap(25, 200);
        reset = 1'b1;
        step();
        sbq.delete();
        check("rstmid_valid", {63'd0, arp_tx_valid}, 64'd0);
        check("rstmid_last", {63'd0, arp_tx_last}, 64'd0);
        check("rstmid_busy", {63'd0, busy}, 64'd0);
        reset = 1'b0;
        prev_stall = 1'b0;
        valid_seen = 0;
        repeat (80) step();
        check("rstmid_no_resume", 64'(valid_seen), 64'd0);
        check("rstmid_busy_after", {63'd0, busy}, 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
